// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-look-ahead adder/subtractor: each stage resolves one SEG_WIDTH-bit
// segment and forwards its carry, with valid/ready flow control on both sides.
module cla_pipelined_adder #(
    parameter  int WIDTH     = 16,
    parameter  int SEG_WIDTH = 4,
    localparam int NSEG      = WIDTH / SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    if ((SEG_WIDTH < 1) || (WIDTH % SEG_WIDTH != 0)) begin : g_bad_width
        $error("cla_pipelined_adder: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic [NSEG-1:0]  v_q, v_d;
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [NSEG-1:0]  c_q, c_d;
    logic             msb_q, msb_d;
    logic [NSEG:0]    rdy;

    logic [NSEG-1:0]  up_v;
    logic [WIDTH-1:0] a_up [NSEG];
    logic [WIDTH-1:0] b_up [NSEG];
    logic [WIDTH-1:0] s_up [NSEG];
    logic [NSEG-1:0]  c_up;

    // Flattened look-ahead: every carry is a sum of generate/propagate products.
    function automatic logic [SEG_WIDTH:0] cla_carries(
        input logic [SEG_WIDTH-1:0] g,
        input logic [SEG_WIDTH-1:0] p,
        input logic                 cin
    );
        logic [SEG_WIDTH:0] c;
        logic               acc;
        logic               pp;
        c[0] = cin;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
        return c;
    endfunction

    always_comb begin : p_ready
        logic r;
        r         = out_ready;
        rdy       = '0;
        rdy[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0];

    // Stage 0 sees the raw operands; operand B is inverted here so sub travels as data.
    always_comb begin : p_upstream
        up_v    = '0;
        c_up    = '0;
        up_v[0] = in_valid;
        a_up[0] = in1;
        b_up[0] = sub ? ~in2 : in2;
        s_up[0] = '0;
        c_up[0] = sub | c_in;
        for (int k = 1; k < NSEG; k++) begin
            up_v[k] = v_q[k-1];
            a_up[k] = a_q[k-1];
            b_up[k] = b_q[k-1];
            s_up[k] = s_q[k-1];
            c_up[k] = c_q[k-1];
        end
    end

    always_comb begin : p_next
        logic [SEG_WIDTH-1:0] g;
        logic [SEG_WIDTH-1:0] p;
        logic [SEG_WIDTH:0]   cc;
        logic [WIDTH-1:0]     s_new;
        v_d   = v_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        msb_d = msb_q;
        g     = '0;
        p     = '0;
        cc    = '0;
        s_new = '0;
        for (int k = 0; k < NSEG; k++) begin
            g     = a_up[k][k*SEG_WIDTH +: SEG_WIDTH] & b_up[k][k*SEG_WIDTH +: SEG_WIDTH];
            p     = a_up[k][k*SEG_WIDTH +: SEG_WIDTH] ^ b_up[k][k*SEG_WIDTH +: SEG_WIDTH];
            cc    = cla_carries(g, p, c_up[k]);
            s_new = s_up[k];
            s_new[k*SEG_WIDTH +: SEG_WIDTH] = p ^ cc[SEG_WIDTH-1:0];
            if (rdy[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    a_d[k] = a_up[k];
                    b_d[k] = b_up[k];
                    s_d[k] = s_new;
                    c_d[k] = cc[SEG_WIDTH];
                    if (k == NSEG - 1) begin
                        msb_d = cc[SEG_WIDTH-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            msb_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            msb_q <= msb_d;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign c_out     = c_q[NSEG-1];
    assign overflow  = msb_q ^ c_q[NSEG-1];

endmodule
